uart_tx_arb: RTL and testbench

- Line-granular round-robin arbiter that shares the single UART transmitter between NUM_REQ byte producers, such as the core MMIO print port and the debug monitor.
- A requester that wins keeps ownership until it sends EOL_CHAR or goes silent for LOCK_TIMEOUT cycles, so text lines from different sources never interleave.
- Output is a registered valid/ready byte stream that drives the transmitter's send request directly.

---
 rtl/uart_tx_arb.sv | 116 +++++++++++
 tb/tb_uart_tx_arb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Line-granular round-robin arbiter sharing one UART transmitter.
// An owner keeps the port until it sends EOL_CHAR or idles out.
module uart_tx_arb #(
  parameter  int         NUM_REQ      = 2,
  parameter  int         LOCK_TIMEOUT = 1024,
  parameter  logic [7:0] EOL_CHAR     = 8'h0A,
  localparam int         OW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  input  logic                 out_ready,
  output logic [OW-1:0]        owner,
  output logic                 locked,
  output logic                 timeout_evt
);

  localparam int CW = $clog2(LOCK_TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] idle_cnt;
  logic [OW-1:0] win;
  logic [7:0]    own_byte;
  logic          any_req;
  logic          xfer;
  logic          is_eol;
  logic          hit_tmo;

  assign any_req = |req_valid;

  // search starts just past the previous owner, wrapping
  always_comb begin : pick
    logic found;
    int   idx;
    win   = owner;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(owner) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = OW'(idx);
      end
    end
  end

  always_comb begin
    own_byte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == OW'(i)) own_byte = req_data[i*8 +: 8];
    end
  end

  assign xfer    = |(req_valid & req_ready);
  assign is_eol  = (own_byte == EOL_CHAR);
  assign hit_tmo = !xfer && (idle_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (any_req) state_d = LOCKED;
      LOCKED: if ((xfer && is_eol) || hit_tmo) state_d = IDLE;
    endcase
  end

  // the output slot accepts a load in the same cycle it drains
  always_comb begin
    req_ready = '0;
    if (state_q == LOCKED) req_ready[owner] = !out_valid || out_ready;
  end

  assign locked = (state_q == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= 8'h00;
      idle_cnt    <= '0;
      owner       <= OW'(NUM_REQ - 1);
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (state_q == IDLE) begin
        if (any_req) begin
          owner    <= win;
          idle_cnt <= '0;
        end
      end else if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= own_byte;
        idle_cnt  <= '0;
      end else if (hit_tmo) begin
        idle_cnt    <= '0;
        timeout_evt <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: randomized producers against a line-level
// reference model, with a scoreboard monitor on the output stream.
module tb_uart_tx_arb;

  localparam int         N   = 4;
  localparam int         LT  = 16;
  localparam logic [7:0] EOL = 8'h0A;
  localparam int         OW  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [7:0]     out_data;
  logic           out_ready = 1'b1;
  logic [OW-1:0]  owner;
  logic           locked;
  logic           timeout_evt;

  uart_tx_arb #(
    .NUM_REQ(N), .LOCK_TIMEOUT(LT), .EOL_CHAR(EOL)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready),
    .owner(owner), .locked(locked),
    .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] byte_q_t[$];

  byte_q_t    src [N];
  logic [7:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         vprob  = 100;
  int         rprob  = 100;

  // reference model: owner index (-1 when free), last owner,
  // consecutive cycles without a transfer, output slot contents
  int         m_cur;
  int         m_last;
  int         m_idle;
  bit         m_full;
  bit         m_tev;
  logic [7:0] m_held;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cur  = -1;
    m_last = N - 1;
    m_idle = 0;
    m_full = 1'b0;
    m_tev  = 1'b0;
    m_held = 8'h00;
  endtask

  function automatic bit busy();
    bit b = exp_q.size() != 0;
    for (int i = 0; i < N; i++) if (src[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic step();
    logic [N-1:0]   v;
    logic [8*N-1:0] d;
    logic [N-1:0]   rdy_e;
    logic [7:0]     b;
    bit             drain;
    bit             found;
    int             j;
    @(negedge clk);
    v = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (src[i].size() != 0) begin
        v[i] = ($urandom_range(99) < vprob);
        d[i*8 +: 8] = src[i][0];
      end
    end
    req_valid = v;
    req_data  = d;
    out_ready = ($urandom_range(99) < rprob);
    #2;
    rdy_e = '0;
    if (m_cur >= 0 && (!m_full || out_ready)) rdy_e[m_cur] = 1'b1;
    chk("req_ready", req_ready, rdy_e);
    chk("locked", locked, m_cur >= 0);
    chk("owner", owner, (m_cur >= 0) ? m_cur : m_last);
    chk("out_valid", out_valid, m_full);
    if (m_full) chk("held_byte", out_data, m_held);
    chk("timeout_evt", timeout_evt, m_tev);
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) void'(src[i].pop_front());
    m_tev = 1'b0;
    drain = m_full && out_ready;
    if (drain) m_full = 1'b0;
    if (m_cur < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (!found && req_valid[j]) begin
          found  = 1'b1;
          m_cur  = j;
          m_idle = 0;
        end
      end
    end else if (req_valid[m_cur] && rdy_e[m_cur]) begin
      b = req_data[m_cur*8 +: 8];
      exp_q.push_back(b);
      m_held = b;
      m_full = 1'b1;
      m_idle = 0;
      if (b == EOL) begin
        m_last = m_cur;
        m_cur  = -1;
      end
    end else begin
      m_idle++;
      if (m_idle == LT) begin
        m_last = m_cur;
        m_cur  = -1;
        m_idle = 0;
        m_tev  = 1'b1;
      end
    end
  endtask

  task automatic drain_all(input int maxc);
    int c = 0;
    while (busy() && c < maxc) begin
      step();
      c++;
    end
    checks++;
    if (busy()) begin
      errors++;
      $display("FAIL drain: %0d bytes pending after %0d cycles, expected 0",
               exp_q.size(), maxc);
    end
  endtask

  task automatic load_lines(input int i, input int n);
    int len;
    for (int l = 0; l < n; l++) begin
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++)
        src[i].push_back(8'($urandom_range(8'h41, 8'h5A)));
      if ($urandom_range(9) > 1) src[i].push_back(EOL);
    end
  endtask

  // scoreboard: every byte the transmitter takes must be next in line
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_data: got %0h expected none", out_data);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int tcnt;
    int c;
    model_reset();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_locked", locked, 0);
    chk("rst_owner", owner, N - 1);
    chk("rst_timeout", timeout_evt, 0);
    rst = 1'b0;

    src[0] = '{8'h48, 8'h69, EOL};
    drain_all(50);
    repeat (2) step();

    src[0] = '{8'h41, 8'h42, EOL};
    src[1] = '{8'h41, 8'h42, EOL};
    drain_all(50);

    for (int i = 0; i < N; i++) src[i] = '{EOL, EOL, EOL};
    drain_all(100);

    src[1] = '{8'h31};
    c = 0;
    while (src[1].size() != 0 && c < 10) begin
      step();
      c++;
    end
    src[0] = '{8'h50, EOL};
    tcnt = 0;
    repeat (25) begin
      step();
      if (timeout_evt) tcnt++;
    end
    chk("tmo_count", tcnt, 1);
    drain_all(50);

    src[2] = '{8'h61, 8'h62, 8'h63, 8'h64};
    rprob = 0;
    repeat (12) step();
    chk("bp_data", out_data, 8'h61);
    chk("bp_ready", req_ready, 0);
    rprob = 100;
    drain_all(100);
    src[3] = '{8'h71, 8'h72};
    rprob = 0;
    repeat (40) step();
    rprob = 100;
    drain_all(200);

    for (int r = 0; r < 4; r++) begin
      vprob = (r == 2) ? 20 : 100 - 20 * r;
      rprob = (r == 3) ? 30 : 90 - 20 * r;
      for (int i = 0; i < N; i++) load_lines(i, 6);
      drain_all(8000);
    end
    vprob = 100;
    rprob = 100;
    repeat (20) step();

    src[0] = '{8'h55, 8'h56, 8'h57};
    rprob = 0;
    repeat (3) step();
    @(posedge clk);
    #2;
    rst = 1'b1;
    req_valid = '0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_req_ready", req_ready, 0);
    chk("arst_locked", locked, 0);
    chk("arst_owner", owner, N - 1);
    model_reset();
    exp_q.delete();
    for (int i = 0; i < N; i++) src[i].delete();
    @(negedge clk);
    rst = 1'b0;
    rprob = 100;
    src[0] = '{8'h81, EOL};
    src[2] = '{8'h82, EOL};
    repeat (2) step();
    chk("arst_first_owner", owner, 0);
    drain_all(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
